// File: rtl/shift_div_ctrl_if.sv
// Handshake and operand/result bus between the operand source and the
// iterative divider controller.
interface shift_div_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dbz;

  // Operand source side
  modport master (
    output start, dividend, divisor,
    input  ready, busy, done, quotient, remainder, dbz
  );

  // Divider side
  modport slave (
    input  start, dividend, divisor,
    output ready, busy, done, quotient, remainder, dbz
  );
endinterface

// File: rtl/shift_div_ctrl.sv
// Iterative unsigned restoring divider controller: one quotient bit per
// clock, MSB of the dividend first. Divide-by-zero short-circuits to DONE
// with quotient all ones and remainder equal to the dividend.
module shift_div_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic           clk,
  input logic           rst,
  shift_div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;
  logic [CNT_W-1:0] cnt_r;
  logic             dbz_r;

  logic [WIDTH:0]   partial_s;
  logic             ge_s;
  logic [WIDTH-1:0] rem_next_s;
  logic             last_iter_s;
  logic             dsr_zero_s;

  // One restoring step: bring in the next dividend bit and trial-subtract.
  // The compare uses WIDTH+1 bits so the shifted-out remainder MSB is kept;
  // when the subtract succeeds the result is below the divisor, so the low
  // WIDTH bits of the difference are exact.
  always_comb begin
    partial_s   = {rem_r, dvd_r[WIDTH-1]};
    ge_s        = (partial_s >= {1'b0, dsr_r});
    if (ge_s) begin
      rem_next_s = partial_s[WIDTH-1:0] - dsr_r;
    end else begin
      rem_next_s = partial_s[WIDTH-1:0];
    end
    last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));
    dsr_zero_s  = (bus.divisor == {WIDTH{1'b0}});
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (dsr_zero_s) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_iter_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture and iteration datapath; results hold outside RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_r  <= {WIDTH{1'b0}};
      dsr_r  <= {WIDTH{1'b0}};
      quot_r <= {WIDTH{1'b0}};
      rem_r  <= {WIDTH{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      dbz_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            dvd_r <= bus.dividend;
            dsr_r <= bus.divisor;
            cnt_r <= {CNT_W{1'b0}};
            if (dsr_zero_s) begin
              quot_r <= {WIDTH{1'b1}};
              rem_r  <= bus.dividend;
              dbz_r  <= 1'b1;
            end else begin
              quot_r <= {WIDTH{1'b0}};
              rem_r  <= {WIDTH{1'b0}};
              dbz_r  <= 1'b0;
            end
          end
        end
        RUN: begin
          rem_r  <= rem_next_s;
          quot_r <= {quot_r[WIDTH-2:0], ge_s};
          dvd_r  <= {dvd_r[WIDTH-2:0], 1'b0};
          cnt_r  <= cnt_r + CNT_W'(1);
        end
        DONE: begin
          dvd_r <= dvd_r;
        end
        default: begin
          dvd_r <= dvd_r;
        end
      endcase
    end
  end

  // Status decoded straight from the state register; results from registers.
  assign bus.ready     = (state_r == IDLE);
  assign bus.busy      = (state_r == RUN);
  assign bus.done      = (state_r == DONE);
  assign bus.quotient  = quot_r;
  assign bus.remainder = rem_r;
  assign bus.dbz       = dbz_r;

endmodule

// File: tb/tb_shift_div_ctrl.sv
// Directed and random checks for shift_div_ctrl (WIDTH=8).
module tb_shift_div_ctrl;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  shift_div_ctrl_if #(.WIDTH(8)) bus ();

  shift_div_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch one operation; optional extra start pulses (9/2) at cycle p1/p2
  // after acceptance and in the DONE cycle. Returns cycles until done (0 on timeout).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input int p1, input int p2, input bit pdone, output int lat);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        lat = i;
        if (pdone) begin
          bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd2;
        end
      end else if (i == p1 || i == p2) begin
        bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd2;
      end
    end
  endtask

  // Check result, latency and that the controller returns to IDLE next cycle.
  task automatic check_op(input string tag, input logic [7:0] a, input logic [7:0] b, input int lat);
    logic [7:0] eq, er;
    logic       ez;
    ez = (b == 8'd0);
    eq = ez ? 8'hFF : a / b;
    er = ez ? a : a % b;
    chk({tag, "_lat"}, lat, ez ? 1 : 9);
    chk({tag, "_q"}, bus.quotient, eq);
    chk({tag, "_r"}, bus.remainder, er);
    chk({tag, "_dbz"}, bus.dbz, ez);
    if (!ez) begin
      chk({tag, "_inv"}, 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
      chk({tag, "_rlt"}, bus.remainder < b, 1'b1);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_done1"}, bus.done, 1'b0);
    chk({tag, "_ready"}, bus.ready, 1'b1);
    chk({tag, "_q_hold"}, bus.quotient, eq);
  endtask

  initial begin
    int   lat;
    bit   saw_done;
    logic [7:0] ra, rb;
    tests = 0;
    failed = 0;
    bus.start = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor = 8'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_dbz", bus.dbz, 1'b0);
    chk("rst_q", bus.quotient, 8'd0);
    chk("rst_r", bus.remainder, 8'd0);

    // Normal divide, with busy visible in the first RUN cycle
    bus.dividend = 8'd200; bus.divisor = 8'd7; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    chk("run_busy", bus.busy, 1'b1);
    chk("run_ready", bus.ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    run_op(8'd200, 8'd7, 0, 0, 1'b0, lat); check_op("d200_7", 8'd200, 8'd7, lat);

    // Edge values
    run_op(8'd255, 8'd1, 0, 0, 1'b0, lat);   check_op("d255_1", 8'd255, 8'd1, lat);
    run_op(8'd5, 8'd9, 0, 0, 1'b0, lat);     check_op("d5_9", 8'd5, 8'd9, lat);
    run_op(8'd0, 8'd3, 0, 0, 1'b0, lat);     check_op("d0_3", 8'd0, 8'd3, lat);
    run_op(8'd255, 8'd255, 0, 0, 1'b0, lat); check_op("d255_255", 8'd255, 8'd255, lat);

    // Divide by zero, then a normal op clears dbz
    run_op(8'd100, 8'd0, 0, 0, 1'b0, lat);   check_op("dbz100", 8'd100, 8'd0, lat);
    run_op(8'd10, 8'd3, 0, 0, 1'b0, lat);    check_op("d10_3", 8'd10, 8'd3, lat);

    // Busy protection: starts in RUN cycles 3 and 8 and in the DONE cycle
    run_op(8'd200, 8'd7, 3, 8, 1'b1, lat);   check_op("busy", 8'd200, 8'd7, lat);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    chk("busy_no_extra_done", saw_done, 1'b0);
    chk("busy_q_stable", bus.quotient, 8'd28);

    // Reset in the 4th RUN cycle
    bus.dividend = 8'd200; bus.divisor = 8'd7; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mrst_ready", bus.ready, 1'b1);
    chk("mrst_busy", bus.busy, 1'b0);
    chk("mrst_q", bus.quotient, 8'd0);
    chk("mrst_r", bus.remainder, 8'd0);
    saw_done = (bus.done === 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    chk("mrst_no_done", saw_done, 1'b0);
    run_op(8'd50, 8'd6, 0, 0, 1'b0, lat);    check_op("d50_6", 8'd50, 8'd6, lat);

    // Random regression including divisor=0
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_op(ra, rb, 0, 0, 1'b0, lat);
      check_op("rand", ra, rb, lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
